// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine.
//   SPI_BITS  : bits per transfer (the bus wrapper always moves bytes)
//   EDGE_W    : width of the sclk edge counter (0 .. 2*SPI_BITS-1)
//   state_t   : engine FSM encoding
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int EDGE_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

endpackage

// File: rtl/spi_shifter.sv
// Transmit / receive shift register pair for one SPI byte.
//   clk, rst   : system clock, synchronous active-high reset
//   load       : capture load_data into the tx register and clear rx
//   load_data  : byte to transmit
//   shift_out  : shift tx left by one (MSB first, zero fill)
//   sample_in  : shift miso into the rx LSB
//   miso       : serial input bit
//   msb        : current tx MSB (the bit being presented)
//   rx_byte    : received bits so far
module spi_shifter
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SPI_BITS-1:0] load_data,
  input  logic                shift_out,
  input  logic                sample_in,
  input  logic                miso,
  output logic                msb,
  output logic [SPI_BITS-1:0] rx_byte
);

  logic [SPI_BITS-1:0] tx_sr;
  logic [SPI_BITS-1:0] rx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (load) begin
      tx_sr <= load_data;
      rx_sr <= '0;
    end else begin
      if (shift_out) tx_sr <= {tx_sr[SPI_BITS-2:0], 1'b0};
      if (sample_in) rx_sr <= {rx_sr[SPI_BITS-2:0], miso};
    end
  end

  assign msb     = tx_sr[SPI_BITS-1];
  assign rx_byte = rx_sr;

endmodule

// File: rtl/spi_master_engine.sv
// Byte-level SPI master shift engine, paced by the clk_spi_en tick.
//   clk, rst    : system clock, synchronous active-high reset
//   clk_spi_en  : one SPI half-period advances per cycle this is high
//   start       : one-cycle pulse, begin a byte with data_write
//   finish      : level, release cs once the engine is idle
//   cpol, cpha  : SPI mode, captured at start
//   data_write  : byte to transmit, captured at start
//   data_read   : last received byte (valid when req_next rises)
//   req_next    : idle and ready for the next start
//   sclk, mosi, miso, cs : SPI pins (cs active low)
//   state_dbg   : current FSM state
//
// Handshake: start is accepted only in a cycle where the engine is IDLE
// (req_next high, except during TRAIL where req_next is high but start is
// ignored); a start in any other state is dropped. req_next falls the cycle
// after an accepted start and rises again with data_read valid.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int LEAD_TICKS  = 1,
  parameter int TRAIL_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_spi_en,
  input  logic       start,
  input  logic       finish,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       req_next,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs,
  output logic [1:0] state_dbg
);

  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2*BITS-1);
  localparam logic [7:0]        LEAD_LAST  = 8'(LEAD_TICKS-1);
  localparam logic [7:0]        TRAIL_LAST = 8'(TRAIL_TICKS-1);

  state_t            state, state_next;
  logic [EDGE_W-1:0] edge_cnt;
  logic [7:0]        tick_cnt;
  logic              cpol_q, cpha_q;
  logic              mosi_r;
  logic              do_load, do_shift, do_sample, byte_done;
  logic              lead_edge;
  logic              tx_msb;
  logic [7:0]        rx_byte;

  spi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (do_load),
    .load_data (data_write),
    .shift_out (do_shift),
    .sample_in (do_sample),
    .miso      (miso),
    .msb       (tx_msb),
    .rx_byte   (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-tick shift strobes. In SHIFT, even edge counts are
  // leading edges. CPHA=0 samples on leading and shifts on trailing; CPHA=1
  // is the reverse, so "shift" is simply cpha_q == lead_edge.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
    byte_done  = 1'b0;
    lead_edge  = ~edge_cnt[0];
    case (state)
      IDLE: begin
        if (start) begin
          do_load    = 1'b1;
          state_next = cs ? LEAD : SHIFT;
        end else if (finish && !cs) begin
          state_next = TRAIL;
        end
      end
      LEAD: begin
        if (clk_spi_en && tick_cnt == LEAD_LAST) state_next = SHIFT;
      end
      SHIFT: begin
        if (clk_spi_en) begin
          do_shift  = (cpha_q == lead_edge);
          do_sample = (cpha_q != lead_edge);
          if (edge_cnt == LAST_EDGE) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      TRAIL: begin
        if (clk_spi_en && tick_cnt == TRAIL_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs        <= 1'b1;
      sclk      <= cpol;
      mosi_r    <= 1'b1;
      data_read <= 8'h00;
      req_next  <= 1'b1;
      edge_cnt  <= '0;
      tick_cnt  <= 8'd0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            edge_cnt <= '0;
            tick_cnt <= 8'd0;
            req_next <= 1'b0;
            cs       <= 1'b0;
          end else if (finish && !cs) begin
            tick_cnt <= 8'd0;
          end
        end
        LEAD: begin
          if (clk_spi_en)
            tick_cnt <= (tick_cnt == LEAD_LAST) ? 8'd0 : tick_cnt + 8'd1;
        end
        SHIFT: begin
          if (clk_spi_en) begin
            // CPHA=1 presents each bit on the leading edge.
            if (cpha_q && do_shift) mosi_r <= tx_msb;
            if (byte_done) begin
              sclk      <= cpol_q;
              edge_cnt  <= '0;
              req_next  <= 1'b1;
              // CPHA=1 samples its last bit on this very tick.
              data_read <= cpha_q ? {rx_byte[6:0], miso} : rx_byte;
              // Hold the last CPHA=0 bit on the line once the shift
              // register stops driving mosi.
              if (!cpha_q) mosi_r <= tx_msb;
            end else begin
              sclk     <= ~sclk;
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (clk_spi_en) begin
            if (tick_cnt == TRAIL_LAST) begin
              cs       <= 1'b1;
              mosi_r   <= 1'b1;
              tick_cnt <= 8'd0;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // CPHA=0 drives the tx MSB straight from the shift register so the bit is
  // already on the line before the first leading edge and follows each
  // trailing-edge shift without an extra register stage.
  assign mosi      = (!cpha_q && (state == LEAD || state == SHIFT)) ? tx_msb : mosi_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_master_engine.sv
module tb_spi_master_engine;
  import spi_pkg::*;

  logic       clk, rst, clk_spi_en, start, finish, cpol, cpha, miso;
  logic [7:0] data_write, data_read;
  logic       req_next, sclk, mosi, cs;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  spi_master_engine #(.BITS(8), .LEAD_TICKS(1), .TRAIL_TICKS(1)) dut (
    .clk(clk), .rst(rst), .clk_spi_en(clk_spi_en), .start(start),
    .finish(finish), .cpol(cpol), .cpha(cpha), .data_write(data_write),
    .data_read(data_read), .req_next(req_next), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs(cs), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tick_div = 1;
  int tick_phase = 0;
  initial begin
    clk_spi_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase = (tick_phase + 1) % tick_div;
      clk_spi_en = (tick_phase == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model ----------------
  logic       loop_mode = 1'b0;
  logic       s_cpol = 1'b0, s_cpha = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         slave_seq = 0;
  int         slave_seen = 0;
  logic [7:0] slave_sr = 8'h00;
  logic       slave_bit = 1'b0;
  logic       sclk_prev = 1'b0;

  assign miso = loop_mode ? mosi : slave_bit;

  // A slave changes its output on the edge the master does not sample on.
  always @(negedge clk) begin
    if (slave_seq != slave_seen) begin
      slave_seen = slave_seq;
      slave_sr   = slave_byte;
      slave_bit  = slave_byte[7];
    end else if (cs === 1'b0 && sclk !== sclk_prev &&
                 ((sclk != s_cpol) == s_cpha)) begin
      if (s_cpha) slave_bit = slave_sr[7];
      slave_sr = {slave_sr[6:0], 1'b0};
      if (!s_cpha) slave_bit = slave_sr[7];
    end
    sclk_prev = sclk;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] slave;
    logic       loop;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver tasks ----------------
  task automatic run_byte(input vec_t v, input bit lead, input bit mid, input string tag);
    int         cyc, edges, first_edge;
    logic       prev;
    logic [7:0] cap;
    bit         cs_rose;
    logic       ledge;
    cpol = v.cpol; cpha = v.cpha; loop_mode = v.loop;
    s_cpol = v.cpol; s_cpha = v.cpha; slave_byte = v.slave; slave_seq++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    check({tag, ".rdy"}, int'(req_next), 1);
    data_write = v.tx; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_write = 8'h00;
    @(negedge clk);
    cyc = 1;
    check({tag, ".cs_low"}, int'(cs), 0);
    check({tag, ".busy"}, int'(req_next), 0);
    prev = sclk; edges = 0; first_edge = 0; cap = 8'h00; cs_rose = 1'b0;
    while (!req_next && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cs) cs_rose = 1'b1;
      if (sclk !== prev) begin
        if (edges == 0) first_edge = cyc;
        edges++;
        ledge = (sclk != v.cpol);
        if (ledge != v.cpha) cap = {cap[6:0], mosi};
        prev = sclk;
      end
      if (mid && cyc == 6) begin
        start = 1'b1; data_write = 8'hFF; cpha = ~v.cpha; cpol = ~v.cpol;
      end else if (mid && cyc == 7) begin
        start = 1'b0; data_write = 8'h00; cpha = v.cpha; cpol = v.cpol;
      end
    end
    check({tag, ".done"}, int'(req_next), 1);
    check({tag, ".rx"}, int'(data_read), int'(v.exp_rx));
    check({tag, ".mosi_bits"}, int'(cap), int'(v.tx));
    check({tag, ".edges"}, edges, 16);
    check({tag, ".sclk_idle"}, int'(sclk), int'(v.cpol));
    check({tag, ".cs_held"}, int'(cs_rose), 0);
    if (tick_div == 1) begin
      check({tag, ".latency"}, cyc, lead ? 18 : 17);
      check({tag, ".first_edge"}, first_edge, lead ? 3 : 2);
    end
  endtask

  task automatic release_cs(input string tag);
    int n;
    n = 0;
    finish = 1'b1;
    while (!cs && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".cs_high"}, int'(cs), 1);
    check({tag, ".mosi_idle"}, int'(mosi), 1);
    finish = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   n, trail_ticks, toggles, bad;
    bit   seen_trail, req_low, start_sent;
    logic prev;
    vec_t b2b, midv, slow;

    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h5A, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 8'hC3, 8'h96, 1'b0, 8'h96};
    vecs[3] = '{1'b1, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'hF0};
    vecs[4] = '{1'b0, 1'b0, 8'h81, 8'h7E, 1'b0, 8'h7E};
    b2b     = '{1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01};
    midv    = '{1'b0, 1'b1, 8'h6D, 8'h5B, 1'b0, 8'h5B};
    slow    = '{1'b1, 1'b0, 8'h3A, 8'hC5, 1'b0, 8'hC5};

    rst = 1'b1; start = 1'b0; finish = 1'b0; cpol = 1'b0; cpha = 1'b0;
    data_write = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.cs", int'(cs), 1);
    check("rst.sclk", int'(sclk), 0);
    check("rst.mosi", int'(mosi), 1);
    check("rst.data_read", int'(data_read), 0);
    check("rst.req_next", int'(req_next), 1);
    check("rst.state", int'(state_dbg), int'(IDLE));

    for (int i = 0; i < 5; i++) begin
      run_byte(vecs[i], 1'b1, 1'b0, $sformatf("v%0d", i));
      release_cs($sformatf("v%0d", i));
    end

    // back-to-back bytes keep cs low and skip LEAD
    run_byte(vecs[0], 1'b1, 1'b0, "b2b0");
    run_byte(b2b, 1'b0, 1'b0, "b2b1");
    release_cs("b2b");

    // start during SHIFT is dropped; mode/data changes mid-byte ignored
    run_byte(midv, 1'b1, 1'b1, "mid");
    release_cs("mid");

    // slow tick, finish high together with start, start during TRAIL
    tick_div = 4;
    finish = 1'b1;
    run_byte(slow, 1'b1, 1'b0, "slow");
    trail_ticks = 0; seen_trail = 1'b0; req_low = 1'b0; start_sent = 1'b0; n = 0;
    while (!cs && n < 100) begin
      if (state_dbg == TRAIL) begin
        seen_trail = 1'b1;
        if (clk_spi_en) trail_ticks++;
        if (!start_sent) begin
          start = 1'b1; data_write = 8'h55; start_sent = 1'b1;
        end
      end
      if (!req_next) req_low = 1'b1;
      @(negedge clk);
      n++;
      start = 1'b0;
    end
    check("trail.cs_high", int'(cs), 1);
    check("trail.seen", int'(seen_trail), 1);
    check("trail.ticks", trail_ticks, 1);
    check("trail.req_held", int'(req_low), 0);
    check("trail.mosi", int'(mosi), 1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (!cs || !req_next || state_dbg != IDLE) bad++;
    end
    check("trail.start_ignored", bad, 0);
    finish = 1'b0;
    tick_div = 1;

    // reset in the middle of a byte (edge counter at 7)
    cpol = 1'b1; cpha = 1'b1; loop_mode = 1'b0;
    s_cpol = 1'b1; s_cpha = 1'b1; slave_byte = 8'h3C; slave_seq++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1;
    data_write = 8'h96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = sclk; toggles = 0; n = 0;
    while (toggles < 7 && n < 100) begin
      @(negedge clk);
      n++;
      if (sclk !== prev) begin
        toggles++;
        prev = sclk;
      end
    end
    check("midrst.toggles", toggles, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst.cs", int'(cs), 1);
    check("midrst.sclk", int'(sclk), 1);
    check("midrst.req_next", int'(req_next), 1);
    check("midrst.data_read", int'(data_read), 0);
    check("midrst.mosi", int'(mosi), 1);
    check("midrst.state", int'(state_dbg), int'(IDLE));
    run_byte(vecs[1], 1'b1, 1'b0, "post_rst");
    release_cs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
